// File: rtl/spectrum_smoother_if.sv
// Bus between the FFT bin stream, the smoother and the bar renderer.
// master: FFT side / bench (drives bins, watches results); slave: the smoother.
interface spectrum_smoother_if #(
  parameter int NUM_BINS = 32
);
  logic                       i_bin_valid;
  logic                       i_bin_sof;
  logic [15:0]                i_bin_data;
  logic [NUM_BINS-1:0][15:0]  o_fft_data;
  logic                       o_fft_done;
  logic                       o_busy;

  modport master (
    output i_bin_valid, i_bin_sof, i_bin_data,
    input  o_fft_data, o_fft_done, o_busy
  );

  modport slave (
    input  i_bin_valid, i_bin_sof, i_bin_data,
    output o_fft_data, o_fft_done, o_busy
  );
endinterface

// File: rtl/spectrum_smoother.sv
// spectrum_smoother: serial FFT bins -> saturated magnitude -> per-bin
// instant-attack / exponential-decay smoothing -> published packed array.
// Optional macro PEAK_HOLD_EN adds a per-bin peak hold of HOLD_FRAMES frames.
module spectrum_smoother #(
  parameter int NUM_BINS    = 32,
  parameter int DECAY_SHIFT = 3,
  parameter int HOLD_FRAMES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  spectrum_smoother_if.slave bus
);
  localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_PUBLISH = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_BINS-1:0][15:0] work_q;
  logic [NUM_BINS-1:0][15:0] out_q;
  logic                      done_q;

  logic             beat;
  logic [IDX_W-1:0] bin_sel;
  logic [15:0]      held, neg, mag, shr, dec, decayed, decay_val, new_val;

`ifdef PEAK_HOLD_EN
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  logic [NUM_BINS-1:0][HW-1:0] hold_q;
  logic [HW-1:0]               cnt, cnt_new;
`endif

  // Beat qualification and magnitude/decay datapath for the addressed bin
  always_comb begin
    beat    = bus.i_bin_valid &&
              (((state_q == S_IDLE) && bus.i_bin_sof) || (state_q == S_COLLECT));
    // sof restarts the frame at bin 0 whatever the index says
    bin_sel = bus.i_bin_sof ? '0 : idx_q;
    held    = work_q[bin_sel];
    neg     = ~bus.i_bin_data + 16'd1;
    // -32768 has no positive twin: clamp it to full scale
    if (!bus.i_bin_data[15])            mag = bus.i_bin_data;
    else if (bus.i_bin_data == 16'h8000) mag = 16'h7FFF;
    else                                 mag = neg;
    shr       = held >> DECAY_SHIFT;
    // small non-zero values must still reach 0, so decay is at least 1
    if (held == 16'd0)     dec = 16'd0;
    else if (shr == 16'd0) dec = 16'd1;
    else                   dec = shr;
    decayed   = held - dec;
    decay_val = (mag > decayed) ? mag : decayed;
`ifdef PEAK_HOLD_EN
    cnt = hold_q[bin_sel];
    if (mag >= held) begin
      new_val = mag;
      cnt_new = HW'(HOLD_FRAMES);
    end else if (cnt != '0) begin
      new_val = held;
      cnt_new = cnt - HW'(1);
    end else begin
      new_val = decay_val;
      cnt_new = cnt;
    end
`else
    new_val = (mag >= held) ? mag : decay_val;
`endif
  end

  // Frame sequencing: IDLE waits for sof, COLLECT counts bins, PUBLISH is one cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (beat) begin
          if (bin_sel == LAST_IDX) begin
            state_d = S_PUBLISH;
            idx_d   = '0;
          end else begin
            state_d = S_COLLECT;
            idx_d   = bin_sel + IDX_W'(1);
          end
        end
      end
      S_PUBLISH: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, index and working array; partial frames still leave their bins updated
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (beat) work_q[bin_sel] <= new_val;
    end
  end

`ifdef PEAK_HOLD_EN
  // Per-bin hold counters, advanced only when their bin is written
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     hold_q <= '0;
    else if (beat) hold_q[bin_sel] <= cnt_new;
  end
`endif

  // Published copy only moves on PUBLISH so the renderer sees a stable array
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_PUBLISH);
      if (state_q == S_PUBLISH) out_q <= work_q;
    end
  end

  assign bus.o_fft_data = out_q;
  assign bus.o_fft_done = done_q;
  assign bus.o_busy     = (state_q == S_COLLECT);
endmodule

// File: tb/tb_spectrum_smoother.sv
// Randomized + directed bench for spectrum_smoother with a queue scoreboard.
module tb_spectrum_smoother;
  localparam int NB = 32;
  localparam int SH = 3;
  localparam int HF = 4;
  typedef logic [NB-1:0][15:0] frame_t;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  spectrum_smoother_if #(.NUM_BINS(NB)) ss ();
  spectrum_smoother #(.NUM_BINS(NB), .DECAY_SHIFT(SH), .HOLD_FRAMES(HF)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(ss)
  );

  int     errors = 0, checks = 0, pulses = 0;
  frame_t exp_q[$];
  frame_t last_exp = '0;
  frame_t mon_e;
  int     held_m[NB];
  int     hold_m[NB];
  int     fdata[NB];
  int     dexp[$];
  int     p0;

  // ---------------- reference model (spec arithmetic on ints) ----------------
  function automatic int mag_of(int d);
    int m = (d < 0) ? -d : d;
    if (m > 32767) m = 32767;
    return m;
  endfunction

  task automatic model_bin(int b, int d);
    int m = mag_of(d);
    int h = held_m[b];
    int dc;
    if (m >= h) begin
      held_m[b] = m;
      hold_m[b] = HF;
    end else begin
`ifdef PEAK_HOLD_EN
      if (hold_m[b] > 0) begin
        hold_m[b] = hold_m[b] - 1;
        return;
      end
`endif
      dc = h >> SH;
      if (dc == 0) dc = 1;
      held_m[b] = (h - dc > m) ? h - dc : m;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin held_m[i] = 0; hold_m[i] = 0; end
  endtask

  function automatic frame_t snap();
    frame_t f;
    for (int i = 0; i < NB; i++) f[i] = 16'(held_m[i]);
    return f;
  endfunction

  function automatic int rnd_bin();
    logic [15:0] r = 16'($urandom);
    case ($urandom_range(0, 3))
      0, 1:    return 0;
      2:       return int'($urandom_range(0, 400)) - 200;
      default: return int'($signed(r));
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_cycle();
    ss.i_bin_valid = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic beat(bit sof, int d);
    ss.i_bin_valid = 1'b1;
    ss.i_bin_sof   = sof;
    ss.i_bin_data  = 16'(d);
    @(posedge i_clk); #1;
    ss.i_bin_valid = 1'b0;
    ss.i_bin_sof   = 1'b0;
  endtask

  task automatic clear_fdata();
    for (int i = 0; i < NB; i++) fdata[i] = 0;
  endtask

  task automatic rand_fdata();
    for (int i = 0; i < NB; i++) fdata[i] = rnd_bin();
  endtask

  // Sends nbeats of fdata starting with sof; a full frame also checks done timing.
  task automatic send_frame(int nbeats, bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ss.i_bin_sof  = 1'($urandom);
          ss.i_bin_data = 16'($urandom);
          idle_cycle();
        end
      end
      beat(i == 0, fdata[i]);
      model_bin(i, fdata[i]);
      if (i == 0 && nbeats > 1) chk("busy_in_frame", int'(ss.o_busy), 1);
    end
    if (nbeats == NB) begin
      exp_q.push_back(snap());
      chk("done_not_early", int'(ss.o_fft_done), 0);
      @(posedge i_clk); #1;
      chk("done_rise", int'(ss.o_fft_done), 1);
      chk("busy_after_frame", int'(ss.o_busy), 0);
      @(posedge i_clk); #1;
      chk("done_fall", int'(ss.o_fft_done), 0);
    end
  endtask

  task automatic do_reset();
    #2;
    i_rst = 1'b1;
    ss.i_bin_valid = 1'b0;
    last_exp = '0;
    model_reset();
    #1;
    chk("rst_data_zero", int'(ss.o_fft_data == '0), 1);
    chk("rst_done_zero", int'(ss.o_fft_done), 0);
    chk("rst_busy_zero", int'(ss.o_busy), 0);
    #12;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge i_clk) begin
    if (!i_rst) begin
      checks++;
      if (ss.o_fft_done) begin
        pulses++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pulse");
        end else begin
          mon_e = exp_q.pop_front();
          if (ss.o_fft_data !== mon_e) begin
            errors++;
            for (int i = 0; i < NB; i++)
              if (ss.o_fft_data[i] !== mon_e[i]) begin
                $display("FAIL frame_data bin %0d: got %0d expected %0d", i, ss.o_fft_data[i], mon_e[i]);
                break;
              end
          end
          last_exp = mon_e;
        end
      end else if (ss.o_fft_data !== last_exp) begin
        errors++;
        $display("FAIL data_unstable: got bin0=%0d expected bin0=%0d", ss.o_fft_data[0], last_exp[0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    i_rst = 1'b1;
    ss.i_bin_valid = 1'b0;
    ss.i_bin_sof   = 1'b0;
    ss.i_bin_data  = '0;
    model_reset();
    #1;
    chk("init_data_zero", int'(ss.o_fft_data == '0), 1);
    chk("init_done_zero", int'(ss.o_fft_done), 0);
    chk("init_busy_zero", int'(ss.o_busy), 0);
    #21;
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // attack
    clear_fdata();
    fdata[0] = 100;
    fdata[5] = -300;
    send_frame(NB, 0);
    chk("attack_bin0", int'(ss.o_fft_data[0]), 100);
    chk("attack_bin5", int'(ss.o_fft_data[5]), 300);
    chk("attack_bin1", int'(ss.o_fft_data[1]), 0);
    chk("attack_bin31", int'(ss.o_fft_data[31]), 0);

    // decay from 100
`ifdef PEAK_HOLD_EN
    dexp = '{100, 100, 100, 100, 88, 77};
`else
    dexp = '{88, 77, 68};
`endif
    clear_fdata();
    foreach (dexp[k]) begin
      send_frame(NB, 0);
      chk("decay_from_100", int'(ss.o_fft_data[0]), dexp[k]);
    end

    // reset in the middle of a frame
    rand_fdata();
    send_frame(10, 0);
    do_reset();
    beat(0, 7);
    chk("idle_after_reset", int'(ss.o_busy), 0);

    // decay from a small value
    clear_fdata();
    fdata[0] = 3;
    send_frame(NB, 0);
    chk("small_attack", int'(ss.o_fft_data[0]), 3);
`ifdef PEAK_HOLD_EN
    dexp = '{3, 3, 3, 3, 2, 1};
`else
    dexp = '{2, 1, 0, 0};
`endif
    clear_fdata();
    foreach (dexp[k]) begin
      send_frame(NB, 0);
      chk("decay_from_3", int'(ss.o_fft_data[0]), dexp[k]);
    end

    // saturation
    clear_fdata();
    fdata[2] = -32768;
    fdata[3] = 32767;
    send_frame(NB, 0);
    chk("sat_neg_full", int'(ss.o_fft_data[2]), 32767);
    chk("sat_bit15", int'(ss.o_fft_data[2][15]), 0);
    chk("sat_pos_full", int'(ss.o_fft_data[3]), 32767);

    // sof after 10 bins then a full frame: one pulse only
    p0 = pulses;
    rand_fdata();
    send_frame(10, 0);
    rand_fdata();
    send_frame(NB, 0);
    chk("abort_one_done", pulses - p0, 1);

    // beats without sof in IDLE are ignored
    p0 = pulses;
    repeat (5) beat(0, rnd_bin());
    repeat (3) idle_cycle();
    chk("idle_no_sof_done", pulses - p0, 0);
    chk("idle_no_sof_busy", int'(ss.o_busy), 0);

    // gapped frame must land where the gap-free model says
    do_reset();
    rand_fdata();
    send_frame(NB, 1);

    // random soak with occasional aborted frames
    for (int f = 0; f < 30; f++) begin
      rand_fdata();
      if ($urandom_range(0, 5) == 0) send_frame(int'($urandom_range(1, NB - 1)), 1'($urandom));
      else send_frame(NB, 1'($urandom));
    end

    repeat (4) idle_cycle();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spectrum_smoother.md
Name: spectrum_smoother

Overview:
- Sits between the FFT core and the VGA bar renderer.
- Accepts one frame of 32 signed 16-bit FFT bins as a serial stream and converts each bin to a saturated magnitude.
- Applies per-bin instant-attack / exponential-decay smoothing so bars fall gracefully instead of flickering.
- Publishes the 32 smoothed values as a packed array with a one-cycle done pulse, which the renderer consumes directly.

Parameters:
- NUM_BINS, 32, bins per frame; output array depth; bin index counter width is clog2(NUM_BINS).
- DECAY_SHIFT, 3, decay per frame = held >> DECAY_SHIFT, minimum 1 while held > 0.
- HOLD_FRAMES, 4, frames a new peak is held before decay starts; used only with PEAK_HOLD_EN.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_bin_valid  input  1  i_bin_data/i_bin_sof valid this cycle.
- i_bin_sof  input  1  marks bin 0 of a frame; qualified by i_bin_valid.
- i_bin_data  input  16  signed two's-complement bin value.
- o_fft_data  output  [NUM_BINS-1:0][15:0]  smoothed magnitudes; bit 15 always 0.
- o_fft_done  output  1  one-cycle pulse; o_fft_data updated this cycle.
- o_busy  output  1  high while in COLLECT.

Behaviour:
- Reset (async, i_rst=1):
  - State goes to IDLE; bin index = 0.
  - Working array, hold counters and o_fft_data all clear to 0.
  - o_fft_done=0, o_busy=0.
- Magnitude: mag = data[15] ? -data : data. The input -32768 saturates to 32767. mag is 15 bits, zero-extended to 16.
- Per-bin update (held = current working value for this bin):
  - dec = (held >> DECAY_SHIFT), forced to 1 if that is 0 and held > 0; dec = 0 if held = 0.
  - new = (mag >= held) ? mag : max(mag, held - dec).
  - No underflow is possible.
- State machine:
  - IDLE:
    - Accepted beat (i_bin_valid=1) with i_bin_sof=1: update bin 0, index := 1, go to COLLECT.
    - Accepted beat with i_bin_sof=0: ignored.
  - COLLECT:
    - Each accepted beat updates bin[index], then index increments.
    - Accepted beat with i_bin_sof=1 at any point: discard the partial frame and restart at bin 0. Bins already updated in the working array keep their new values; nothing is published.
    - Beat at index NUM_BINS-1: go to PUBLISH.
  - PUBLISH (exactly one cycle):
    - o_fft_data := working array; o_fft_done=1; go to IDLE.
    - An i_bin_valid in this cycle is ignored, including sof. Upstream guarantees at least one idle cycle between frames.
- Latency: if the last bin is sampled at edge t, the working array is updated at t. o_fft_data changes and o_fft_done rises at edge t+1; o_fft_done falls at edge t+2.
- o_fft_data is stable between done pulses, because the renderer samples it asynchronously to frames.
- o_fft_done never pulses for an incomplete frame.
- Index wrap: the counter never exceeds NUM_BINS-1; it returns to 0 on entry to IDLE.
- i_bin_valid=0 gaps inside a frame are allowed and stall the counter indefinitely.
- Reset mid-frame: partial data is lost; the first output after reset reflects only post-reset frames.

Optional Feature:
- Macro: PEAK_HOLD_EN.
- Defined:
  - Each bin has a hold counter, width clog2(HOLD_FRAMES+1), reset 0.
  - When mag >= held: new = mag and counter := HOLD_FRAMES.
  - Otherwise, if counter > 0: new = held and counter decrements.
  - Otherwise: normal decay.
- Undefined: no hold counters; decay applies from the first frame after a peak.

Test Plan:
- Reset: assert i_rst mid-stream -> o_fft_data all 0, o_fft_done=0, o_busy=0 immediately (async), and the state is IDLE after release.
- Attack: frame with bin0=100, bin5=-300, others 0 -> one done pulse; o[0]=100, o[5]=300, others 0; done rises 1 cycle after bin 31 is sampled.
- Decay (macro off, DECAY_SHIFT=3): feed zero frames after o[0]=100 -> 88, 77, 68. After o[0]=3 -> 2, 1, 0, 0.
- Saturation: bin2=-32768 -> o[2]=32767, bit 15 is 0. bin3=32767 -> 32767.
- Framing:
  - sof after 10 bins, then a full 32-bin frame -> exactly one done pulse, after the full frame.
  - Beats without sof in IDLE -> ignored, no done.
  - valid gaps inside a frame -> same result as a gapless frame.
- PEAK_HOLD_EN, HOLD_FRAMES=4: o[0]=100, then zero frames -> 100, 100, 100, 100, 88, 77.
